// File: rtl/eth_helper_pkg.sv
// Shared types and constants for the AXI-to-stream converters and the source arbiter.
package eth_helper_pkg;

   typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

   // Stream type codes carried by the converters in their metadata beat
   localparam logic [2:0] STREAM_TYPE_AR = 3'b000;
   localparam logic [2:0] STREAM_TYPE_AW = 3'b001;
   localparam logic [2:0] STREAM_TYPE_R  = 3'b010;
   localparam logic [2:0] STREAM_TYPE_W  = 3'b011;
   localparam logic [2:0] STREAM_TYPE_B  = 3'b100;

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry skid buffer; in_ready is registered and means "at least one entry free".
module stream_skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic [1:0]       count_nx;
   logic             push;
   logic             pop;

   assign out_valid = (count != 2'd0);
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      count_nx = count;
      unique case ({push, pop})
         2'b10:   count_nx = count + 2'd1;
         2'b01:   count_nx = count - 2'd1;
         default: count_nx = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem[0]   <= '0;
         mem[1]   <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count    <= 2'd0;
         in_ready <= 1'b1;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count    <= count_nx;
         in_ready <= (count_nx != 2'd2);
      end
   end

endmodule

// File: rtl/stream_source_arbiter.sv
// Packet-locked round-robin arbiter merging converter streams into one AXI-Stream.
//  state      | meaning
//  ARB_IDLE   | pick next source (in_progress first, else round-robin from rr_ptr)
//  ARB_LOCKED | forward beats of the granted source until its last beat is accepted
module stream_source_arbiter
   import eth_helper_pkg::*;
#(
   parameter int DATA_WIDTH = 128,
   parameter int NUM_SRC    = 5,
   parameter int IDX_WIDTH  = 3
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_SRC-1:0]            src_valid,
   input  logic [NUM_SRC-1:0]            src_in_progress,
   input  logic [NUM_SRC-1:0]            src_last,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
   output logic [NUM_SRC-1:0]            src_ready,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic [IDX_WIDTH-1:0]          m_axis_tid,
   output logic                          m_axis_tlast,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          busy
);

   localparam int SKID_W = DATA_WIDTH + IDX_WIDTH + 1;

   arb_state_t            state, state_nx;
   logic [IDX_WIDTH-1:0]  grant, grant_nx;
   logic [IDX_WIDTH-1:0]  rr_ptr, rr_ptr_nx;
   logic                  skid_can_accept;
   logic                  accept;
   logic                  sel_valid;
   logic                  sel_last;
   logic [DATA_WIDTH-1:0] sel_data;

   // A mid-packet source always wins (lowest index); otherwise first requester from ptr
   function automatic logic [IDX_WIDTH-1:0] rr_pick(
      input logic [NUM_SRC-1:0]   req,
      input logic [NUM_SRC-1:0]   ip,
      input logic [IDX_WIDTH-1:0] ptr
   );
      logic found;
      int   idx;
      rr_pick = '0;
      found   = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (ip[i]) begin
            rr_pick = IDX_WIDTH'(i);
            found   = 1'b1;
         end
      end
      if (!found) begin
         for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (req[idx]) rr_pick = IDX_WIDTH'(idx);
         end
      end
   endfunction

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant == IDX_WIDTH'(i)) begin
            sel_valid = src_valid[i];
            sel_last  = src_last[i];
            sel_data  = src_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      state_nx  = state;
      grant_nx  = grant;
      rr_ptr_nx = rr_ptr;
      src_ready = '0;
      accept    = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (|(src_valid | src_in_progress)) begin
               grant_nx = rr_pick(src_valid | src_in_progress, src_in_progress, rr_ptr);
               state_nx = ARB_LOCKED;
            end
         end
         ARB_LOCKED: begin
            for (int i = 0; i < NUM_SRC; i++) begin
               if (grant == IDX_WIDTH'(i)) src_ready[i] = skid_can_accept;
            end
            accept = sel_valid && skid_can_accept;
            if (accept && sel_last) begin
               state_nx  = ARB_IDLE;
               rr_ptr_nx = (grant == IDX_WIDTH'(NUM_SRC - 1)) ? '0 : grant + IDX_WIDTH'(1);
            end
         end
         default: state_nx = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ARB_IDLE;
         grant  <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_nx;
         grant  <= grant_nx;
         rr_ptr <= rr_ptr_nx;
      end
   end

   assign busy = (state == ARB_LOCKED);

   stream_skid_buffer #(
      .WIDTH (SKID_W)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_data   ({sel_data, grant, sel_last}),
      .in_valid  (accept),
      .in_ready  (skid_can_accept),
      .out_data  ({m_axis_tdata, m_axis_tid, m_axis_tlast}),
      .out_valid (m_axis_tvalid),
      .out_ready (m_axis_tready)
   );

endmodule
